input_conditioner: RTL

Parametrised player-input front end for arcade cores: per-player joystick synchronisation, debounce and opposing-direction (SOCD) resolution, plus queued, fixed-width coin pulse generation. It sits between the `hps_io` joystick words and the game core's active-low switch banks. It replaces the single-player directional filter and single coin pulse helper with one N-player, mode-selectable block.

---
 rtl/input_cond_pkg.sv | 46 ++++
 rtl/coin_pulser.sv | 92 +++++++++
 rtl/input_conditioner.sv | 119 +++++++++++
 3 files changed

// File: rtl/input_cond_pkg.sv
// Shared types, direction bit indices and the per-axis SOCD resolver for the input conditioner.
// Latency: none (definitions and a combinational helper only).
// Backpressure: none.
package input_cond_pkg;

  typedef enum logic [1:0] {
    LAST    = 2'b00,
    NEUTRAL = 2'b01,
    FIRST   = 2'b10,
    RAW     = 2'b11
  } socd_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PULSE = 2'b01,
    GAP   = 2'b10
  } pulser_state_t;

  // Bit positions inside one player's direction nibble {U,D,L,R}.
  localparam int DIR_R = 0;
  localparam int DIR_L = 1;
  localparam int DIR_D = 2;
  localparam int DIR_U = 3;

  // Resolve one axis. bits/last_dir are {L,R} or {U,D}; last_dir 01 means R/D pressed last.
  function automatic logic [1:0] socd_axis(input logic [1:0] bits,
                                           input logic [1:0] last_dir,
                                           input socd_mode_t mode);
    logic [1:0] res;
    res = bits;
    if (bits == 2'b11 && mode != RAW) begin
      if (last_dir == 2'b00) begin
        res = 2'b00;
      end else begin
        case (mode)
          LAST:    res = last_dir;
          NEUTRAL: res = 2'b00;
          FIRST:   res = ~last_dir;
          default: res = bits;
        endcase
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/coin_pulser.sv
// Turns debounced coin releases into fixed-width coin pulses, queueing up to COIN_Q pending coins.
// Latency: release seen on coin -> pulse rises 2 edges later when idle; high PULSE_LEN, low >= GAP_LEN between pulses.
// Backpressure: none; a release arriving with a full queue is discarded and flagged on drop for one cycle.
module coin_pulser
  import input_cond_pkg::*;
#(
  parameter int PULSE_W   = 20,
  parameter int PULSE_LEN = 20'hFFFFF,
  parameter int GAP_LEN   = 20'h40000,
  parameter int COIN_Q    = 3
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic coin,
  output logic pulse,
  output logic drop
);

  localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(PULSE_LEN - 1);
  localparam logic [PULSE_W-1:0] GAP_LOAD   = PULSE_W'(GAP_LEN - 1);
  localparam logic [2:0]         QMAX       = 3'(COIN_Q);

  pulser_state_t      state, state_nxt;
  logic [PULSE_W-1:0] cnt, cnt_nxt;
  logic [2:0]         pending, pending_nxt;
  logic               coin_q;
  logic               release_evt, full, inc, take, drop_nxt;

  // A coin counts when the button is let go; saturation uses the pre-decrement count.
  assign release_evt = coin_q & ~coin;
  assign full        = (pending == QMAX);
  assign inc         = release_evt & ~full;
  assign drop_nxt    = release_evt & full;
  assign pulse       = (state == PULSE);

  // Next-state, counter reload and queue bookkeeping.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    case (state)
      IDLE: begin
        if (pending != 3'd0) begin
          state_nxt = PULSE;
          cnt_nxt   = PULSE_LOAD;
          take      = 1'b1;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if (pending != 3'd0) begin
            state_nxt = PULSE;
            cnt_nxt   = PULSE_LOAD;
            take      = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    pending_nxt = pending + {2'b00, inc} - {2'b00, take};
  end

  // State, counter, queue and drop strobe registers; reset abandons any pulse in progress.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= 3'd0;
      coin_q  <= 1'b0;
      drop    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
      coin_q  <= coin;
      drop    <= drop_nxt;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// N-player joystick/coin front end: synchronise, debounce, resolve opposing directions, generate coin pulses.
// Latency: dir_in -> dir_out DEBOUNCE+3 edges; coin release -> coin_out DEBOUNCE+4 edges when the pulser is idle.
// Backpressure: none; excess coins beyond the per-player queue are dropped and reported on coin_drop.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int PLAYERS   = 2,
  parameter int DEBOUNCE  = 1,
  parameter int PULSE_W   = 20,
  parameter int PULSE_LEN = 20'hFFFFF,
  parameter int GAP_LEN   = 20'h40000,
  parameter int COIN_Q    = 3
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic [PLAYERS*4-1:0]   dir_in,
  input  logic [PLAYERS-1:0]     coin_in,
  output logic [PLAYERS*4-1:0]   dir_out,
  output logic [PLAYERS-1:0]     coin_out,
  output logic [PLAYERS-1:0]     coin_drop
);

  localparam int ND = PLAYERS * 4;
  localparam int NB = ND + PLAYERS;
  localparam int CW = $clog2(DEBOUNCE + 1);

  // Coin buttons sit above the direction bits so one sync/debounce chain serves both.
  logic [NB-1:0] raw, s1, s2, deb;
  logic [ND-1:0] rise, socd;
  socd_mode_t    mode_e;

  assign raw    = {coin_in, dir_in};
  assign mode_e = socd_mode_t'(mode);

  // Two-flop synchroniser for every input bit.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_deb
    logic [CW-1:0] cnt;
    logic          deb_b;
    logic          settle;

    assign settle = (cnt == CW'(DEBOUNCE - 1));
    assign deb[b] = deb_b;

    // Accept a new level only after it differs from deb for DEBOUNCE consecutive cycles.
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        cnt   <= '0;
        deb_b <= 1'b0;
      end else if (s2[b] == deb_b) begin
        cnt <= '0;
      end else if (settle) begin
        deb_b <= s2[b];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    // Flag the rise on the same edge deb changes so last_dir and deb stay consistent.
    if (b < ND) begin : g_rise
      assign rise[b] = s2[b] & ~deb_b & settle;
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    for (genvar a = 0; a < 2; a++) begin : g_axis
      localparam int LO = 4 * p + ((a == 0) ? DIR_R : DIR_D);
      localparam int HI = 4 * p + ((a == 0) ? DIR_L : DIR_U);
      logic [1:0] last_dir;

      // Remember which side of the axis was pressed most recently; R/D wins a simultaneous press.
      always_ff @(posedge clk_sys) begin
        if (reset) begin
          last_dir <= 2'b00;
        end else if (rise[LO]) begin
          last_dir <= 2'b01;
        end else if (rise[HI]) begin
          last_dir <= 2'b10;
        end
      end

      assign {socd[HI], socd[LO]} = socd_axis({deb[HI], deb[LO]}, last_dir, mode_e);
    end

    coin_pulser #(
      .PULSE_W  (PULSE_W),
      .PULSE_LEN(PULSE_LEN),
      .GAP_LEN  (GAP_LEN),
      .COIN_Q   (COIN_Q)
    ) u_coin (
      .clk_sys(clk_sys),
      .reset  (reset),
      .coin   (deb[ND+p]),
      .pulse  (coin_out[p]),
      .drop   (coin_drop[p])
    );
  end

  // Register the resolved directions.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dir_out <= '0;
    end else begin
      dir_out <= socd;
    end
  end

endmodule
